// File: rtl/uart_top_package.sv
// Shared register map, LSR bit positions and bridge state type for the uart_top register bus.
package uart_top_package;

  // Registers sit on 32-bit word boundaries, so register n lives at byte address n*4.
  function automatic logic [15:0] reg_adr(input int unsigned idx);
    return 16'(idx * 4);
  endfunction

  localparam logic [15:0] AdrThr = reg_adr(0);
  localparam logic [15:0] AdrRbr = reg_adr(0);
  localparam logic [15:0] AdrDll = reg_adr(0);
  localparam logic [15:0] AdrIer = reg_adr(1);
  localparam logic [15:0] AdrDlm = reg_adr(1);
  localparam logic [15:0] AdrFcr = reg_adr(2);
  localparam logic [15:0] AdrLcr = reg_adr(3);
  localparam logic [15:0] AdrLsr = reg_adr(5);

  localparam int unsigned LsrDr   = 0;
  localparam int unsigned LsrThre = 5;

  localparam logic [7:0] LcrDlab = 8'h80;
  localparam logic [7:0] FcrInit = 8'h07;
  localparam logic [7:0] IerInit = 8'h00;

  typedef enum logic [3:0] {
    StInitLcrDlab,
    StInitDll,
    StInitDlm,
    StInitLcr,
    StInitFcr,
    StInitIer,
    StPollLsr,
    StReadRbr,
    StWriteThr
  } uart_state_e;

endpackage

// File: rtl/uart_stream_bridge.sv
// Configures a Wishbone-attached 16550-style UART, then moves bytes between it and a
// valid/ready byte stream pair by polling LSR.
module uart_stream_bridge
  import uart_top_package::*;
#(
  parameter logic [15:0] DIVISOR = 16'd27,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  output logic [15:0] adr_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        init_done_o,
  output logic        bus_err_o
);

  uart_state_e r_state;
  uart_state_e w_state_nxt;

  logic        r_stb;
  logic        r_we;
  logic [15:0] r_adr;
  logic [7:0]  r_dat;
  logic [15:0] r_to_cnt;
  logic        r_bus_err;
  logic        r_init_done;
  logic [7:0]  r_tx_data;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;

  logic        w_stb_nxt;
  logic        w_we_nxt;
  logic [15:0] w_adr_nxt;
  logic [7:0]  w_dat_nxt;
  logic [15:0] w_to_cnt_nxt;
  logic        w_bus_err_nxt;
  logic        w_init_done_nxt;
  logic [7:0]  w_tx_data_nxt;
  logic        w_rx_load;

  logic        w_req_we;
  logic [15:0] w_req_adr;
  logic [7:0]  w_req_dat;
  logic        w_unused_dat;

  // Only the low byte of the UART data bus carries register contents.
  assign w_unused_dat = ^dat_i[31:8];

  // State register.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state <= StInitLcrDlab;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Decode the access for the current state, sequence the bus and pick the next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_stb_nxt       = r_stb;
    w_we_nxt        = r_we;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_to_cnt_nxt    = r_to_cnt;
    w_bus_err_nxt   = 1'b0;
    w_init_done_nxt = r_init_done;
    w_tx_data_nxt   = r_tx_data;
    w_rx_load       = 1'b0;
    w_req_we        = 1'b1;
    w_req_adr       = AdrLcr;
    w_req_dat       = LCR_VAL | LcrDlab;

    unique case (r_state)
      StInitLcrDlab: begin
        w_req_adr = AdrLcr;
        w_req_dat = LCR_VAL | LcrDlab;
      end
      StInitDll: begin
        w_req_adr = AdrDll;
        w_req_dat = DIVISOR[7:0];
      end
      StInitDlm: begin
        w_req_adr = AdrDlm;
        w_req_dat = DIVISOR[15:8];
      end
      StInitLcr: begin
        w_req_adr = AdrLcr;
        w_req_dat = LCR_VAL;
      end
      StInitFcr: begin
        w_req_adr = AdrFcr;
        w_req_dat = FcrInit;
      end
      StInitIer: begin
        w_req_adr = AdrIer;
        w_req_dat = IerInit;
      end
      StPollLsr: begin
        w_req_we  = 1'b0;
        w_req_adr = AdrLsr;
        w_req_dat = 8'h00;
      end
      StReadRbr: begin
        w_req_we  = 1'b0;
        w_req_adr = AdrRbr;
        w_req_dat = 8'h00;
      end
      StWriteThr: begin
        w_req_adr = AdrThr;
        w_req_dat = r_tx_data;
      end
      default: ;
    endcase

    if (!r_stb) begin
      // Bus idle for at least this cycle: launch the access belonging to the current state.
      w_stb_nxt    = 1'b1;
      w_we_nxt     = w_req_we;
      w_adr_nxt    = w_req_adr;
      w_dat_nxt    = w_req_dat;
      w_to_cnt_nxt = 16'd0;
    end else if (ack_i) begin
      w_stb_nxt    = 1'b0;
      w_we_nxt     = 1'b0;
      w_to_cnt_nxt = 16'd0;
      unique case (r_state)
        StInitLcrDlab: w_state_nxt = StInitDll;
        StInitDll:     w_state_nxt = StInitDlm;
        StInitDlm:     w_state_nxt = StInitLcr;
        StInitLcr:     w_state_nxt = StInitFcr;
        StInitFcr:     w_state_nxt = StInitIer;
        StInitIer: begin
          w_state_nxt     = StPollLsr;
          w_init_done_nxt = 1'b1;
        end
        StPollLsr: begin
          // Receive wins over transmit; never read RBR while the holding register is full.
          if (dat_i[LsrDr] && !r_rx_valid) begin
            w_state_nxt = StReadRbr;
          end else if (dat_i[LsrThre] && tx_valid_i) begin
            w_state_nxt   = StWriteThr;
            w_tx_data_nxt = tx_data_i;
          end
        end
        StReadRbr: begin
          w_rx_load   = 1'b1;
          w_state_nxt = StPollLsr;
        end
        StWriteThr:    w_state_nxt = StPollLsr;
        default:       w_state_nxt = StInitLcrDlab;
      endcase
    end else if (r_to_cnt == TIMEOUT - 16'd1) begin
      // Give up on this attempt; the state is unchanged so the same access is relaunched.
      w_stb_nxt     = 1'b0;
      w_we_nxt      = 1'b0;
      w_bus_err_nxt = 1'b1;
      w_to_cnt_nxt  = 16'd0;
    end else begin
      w_to_cnt_nxt = r_to_cnt + 16'd1;
    end
  end

  // Bus master registers, timeout counter and status flags.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 16'h0000;
      r_dat       <= 8'h00;
      r_to_cnt    <= 16'd0;
      r_bus_err   <= 1'b0;
      r_init_done <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_stb       <= w_stb_nxt;
      r_we        <= w_we_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_bus_err   <= w_bus_err_nxt;
      r_init_done <= w_init_done_nxt;
      r_tx_data   <= w_tx_data_nxt;
    end
  end

  // Receive holding register: filled by an RBR read, emptied by the consumer handshake.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
    end else if (w_rx_load) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= dat_i[7:0];
    end else if (r_rx_valid && rx_ready_i) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign cyc_o       = r_stb;
  assign stb_o       = r_stb;
  assign we_o        = r_we;
  assign adr_o       = r_adr;
  assign dat_o       = {24'h000000, r_dat};
  assign sel_o       = {3'b000, r_stb};
  assign bus_err_o   = r_bus_err;
  assign init_done_o = r_init_done;
  assign rx_valid_o  = r_rx_valid;
  assign rx_data_o   = r_rx_data;
  // The producer's byte is consumed exactly when the UART acknowledges the THR write.
  assign tx_ready_o  = (r_state == StWriteThr) && r_stb && ack_i;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Randomised bench: a behavioural UART slave and stream agents drive the bridge, and a
// monitor checks every bus handshake and stream transfer against queued expectations.
module tb_uart_stream_bridge;

  logic        clk = 1'b0;
  logic        nrst_i;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic        cyc_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic        init_done_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  uart_stream_bridge dut (
    .clk_i      (clk),
    .nrst_i     (nrst_i),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .we_o       (we_o),
    .sel_o      (sel_o),
    .stb_o      (stb_o),
    .cyc_o      (cyc_o),
    .dat_i      (dat_i),
    .ack_i      (ack_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .init_done_o(init_done_o),
    .bus_err_o  (bus_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0]  uart_rx[$];  // bytes waiting in the UART receiver
  logic [7:0]  exp_rx[$];   // bytes the rx stream must deliver, in order
  logic [7:0]  tx_src[$];   // bytes the tx producer still has to offer
  logic [7:0]  exp_thr[$];  // bytes offered and not yet seen written to THR
  logic [24:0] init_q[$];   // {we, adr, data} of the expected configuration writes
  bit          withhold = 1'b0;
  bit          withhold_thr = 1'b0;
  bit          rx_ready_en = 1'b1;
  int          max_wait = 0;
  int          thre_pct = 100;
  int          rbr_reads = 0;

  localparam logic [16:0] AccLsr = {1'b0, 16'h0014};
  localparam logic [16:0] AccRbr = {1'b0, 16'h0000};
  localparam logic [16:0] AccThr = {1'b1, 16'h0000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_init();
    init_q.delete();
    init_q.push_back({1'b1, 16'h000C, 8'h83});
    init_q.push_back({1'b1, 16'h0000, 8'h1B});
    init_q.push_back({1'b1, 16'h0004, 8'h00});
    init_q.push_back({1'b1, 16'h000C, 8'h03});
    init_q.push_back({1'b1, 16'h0008, 8'h07});
    init_q.push_back({1'b1, 16'h0004, 8'h00});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cyc"}, cyc_o, 0);
    chk({tag, "_stb"}, stb_o, 0);
    chk({tag, "_we"}, we_o, 0);
    chk({tag, "_tx_ready"}, tx_ready_o, 0);
    chk({tag, "_rx_valid"}, rx_valid_o, 0);
    chk({tag, "_init_done"}, init_done_o, 0);
    chk({tag, "_bus_err"}, bus_err_o, 0);
    chk({tag, "_adr"}, adr_o, 0);
    chk({tag, "_dat"}, dat_o, 0);
    chk({tag, "_sel"}, sel_o, 0);
    chk({tag, "_rx_data"}, rx_data_o, 0);
  endtask

  task automatic inject_rx(input logic [7:0] b);
    uart_rx.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = (init_q.size() == 0) && (tx_src.size() == 0) && !tx_valid_i &&
           (exp_thr.size() == 0) && (exp_rx.size() == 0) && (uart_rx.size() == 0) && init_done_o;
    end
    chk(name, ok, 1);
  endtask

  // UART slave: acks after a random wait, answers LSR/RBR reads, emits stray acks when idle.
  initial begin : slave
    int wait_cnt;
    ack_i = 1'b0;
    dat_i = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (!nrst_i || !(cyc_o && stb_o)) begin
        ack_i = nrst_i && ($urandom_range(0, 7) == 0);
        dat_i = $urandom;
        wait_cnt = $urandom_range(0, max_wait);
      end else if (withhold || (withhold_thr && we_o && adr_o == 16'h0000)) begin
        ack_i = 1'b0;
      end else if (wait_cnt > 0) begin
        ack_i = 1'b0;
        wait_cnt--;
      end else begin
        ack_i = 1'b1;
        dat_i = $urandom;
        if (!we_o && adr_o == 16'h0014) begin
          dat_i[0] = (uart_rx.size() != 0);
          dat_i[5] = ($urandom_range(0, 99) < thre_pct);
        end else if (!we_o && adr_o == 16'h0000) begin
          dat_i[7:0] = (uart_rx.size() != 0) ? uart_rx.pop_front() : 8'h00;
        end
      end
    end
  end

  // Stream agents: tx producer holds each byte until accepted; rx consumer is randomly ready.
  initial begin : stream_agents
    bit hs;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    rx_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      hs = tx_valid_i && tx_ready_o;
      @(posedge clk);
      #1;
      if (hs) tx_valid_i = 1'b0;
      rx_ready_i = rx_ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!tx_valid_i && tx_src.size() != 0 && $urandom_range(0, 2) == 0) begin
        tx_data_i  = tx_src.pop_front();
        tx_valid_i = 1'b1;
        exp_thr.push_back(tx_data_i);
      end
    end
  end

  // Monitor: samples between edges; ack_i and outputs describe the upcoming clock edge.
  initial begin : monitor
    bit          prev_rv;
    bit          prev_rr;
    logic [7:0]  prev_rd;
    bit          expect_done;
    bit          pred_valid;
    logic [16:0] pred;
    logic [16:0] acc;
    logic [24:0] exp_init;
    bit          w_hs;
    prev_rv = 0; prev_rr = 0; prev_rd = 0; expect_done = 0; pred_valid = 0; pred = AccLsr;
    forever begin
      @(negedge clk);
      #2;
      if (!nrst_i) begin
        prev_rv = 0; prev_rr = 0; expect_done = 0; pred_valid = 0;
        continue;
      end
      if (expect_done) begin
        chk("init_done_set", init_done_o, 1);
        expect_done = 0;
      end
      if (prev_rv && !prev_rr) begin
        chk("rx_hold_valid", rx_valid_o, 1);
        chk("rx_hold_data", rx_data_o, prev_rd);
      end
      if (prev_rv && prev_rr) chk("rx_clear", rx_valid_o, 0);
      if (rx_valid_o && rx_ready_i) begin
        if (exp_rx.size() == 0) chk("rx_unexpected", 1, exp_rx.size());
        else chk("rx_data", rx_data_o, exp_rx.pop_front());
      end
      w_hs = cyc_o && stb_o && ack_i && we_o && (adr_o == 16'h0000) && init_done_o;
      if (w_hs || tx_ready_o) chk("tx_ready_on_thr_ack", tx_ready_o, w_hs);
      if (!withhold) chk("bus_err_quiet", bus_err_o, 0);
      if (cyc_o && stb_o && ack_i) begin
        acc = {we_o, adr_o};
        chk("sel", sel_o, 4'b0001);
        chk("dat_hi", dat_o[31:8], 0);
        if (init_q.size() != 0) begin
          exp_init = init_q.pop_front();
          chk("init_access", {we_o, adr_o, dat_o[7:0]}, exp_init);
          chk("init_done_early", init_done_o, 0);
          if (init_q.size() == 0) begin
            expect_done = 1;
            pred = AccLsr;
            pred_valid = 1;
          end
        end else begin
          if (pred_valid) chk("next_access", acc, pred);
          if (acc == AccThr) begin
            if (exp_thr.size() == 0) chk("thr_unexpected", 1, exp_thr.size());
            else chk("thr_data", dat_o[7:0], exp_thr.pop_front());
          end
          if (acc == AccRbr) rbr_reads++;
          if (acc == AccLsr) begin
            if (dat_i[0] && !rx_valid_o) pred = AccRbr;
            else if (dat_i[5] && tx_valid_i) pred = AccThr;
            else pred = AccLsr;
          end else begin
            pred = AccLsr;
          end
          pred_valid = 1;
        end
      end
      prev_rv = rx_valid_o;
      prev_rr = rx_ready_i;
      prev_rd = rx_data_o;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          cnt;
    bit          seen;
    logic [15:0] held_adr;
    logic [7:0]  b0;
    int          rbr_base;
    nrst_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    push_init();
    @(negedge clk);
    #1;
    nrst_i = 1'b1;
    wait_idle("init_zero_wait", 200);

    // Directed: rx and tx both pending, then a lone tx byte.
    inject_rx(8'hC3);
    tx_src.push_back(8'h5A);
    wait_idle("rx_tx_pair", 500);
    tx_src.push_back(8'h5A);
    wait_idle("tx_single", 500);

    // Random mixed traffic with wait states and throttled THRE.
    max_wait = 2;
    thre_pct = 70;
    for (int i = 0; i < 12; i++) tx_src.push_back(8'($urandom));
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(2, 30)) @(posedge clk);
      #1;
      inject_rx(8'($urandom));
    end
    wait_idle("mixed_traffic", 5000);

    // Consumer stalled: exactly one RBR read, byte held until taken.
    thre_pct = 100;
    rx_ready_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rbr_base = rbr_reads;
    b0 = 8'($urandom);
    inject_rx(b0);
    inject_rx(8'($urandom));
    repeat (300) @(negedge clk);
    #2;
    chk("stall_rbr_reads", rbr_reads - rbr_base, 1);
    chk("stall_rx_valid", rx_valid_o, 1);
    chk("stall_rx_data", rx_data_o, b0);
    rx_ready_en = 1'b1;
    wait_idle("stall_drain", 1000);

    // Ack withheld: timeout after 1023 stalled cycles, one idle cycle, same access retried.
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = !stb_o;
    end
    chk("to_idle_found", seen, 1);
    withhold = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = stb_o;
    end
    chk("to_start_found", seen, 1);
    held_adr = adr_o;
    cnt = 0;
    while (stb_o && cnt < 1100) begin
      cnt++;
      @(negedge clk);
      #2;
    end
    chk("to_cycles", cnt, 1023);
    chk("to_bus_err", bus_err_o, 1);
    chk("to_stb_low", stb_o, 0);
    @(negedge clk);
    #2;
    chk("to_retry_stb", stb_o, 1);
    chk("to_retry_adr", adr_o, held_adr);
    chk("to_err_one_cycle", bus_err_o, 0);
    withhold = 1'b0;
    wait_idle("to_recover", 200);

    // Reset while a THR write is outstanding: byte not consumed, init rerun, byte resent.
    max_wait = 1;
    withhold_thr = 1'b1;
    tx_src.push_back(8'hA5);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      #2;
      seen = stb_o && we_o && (adr_o == 16'h0000) && init_done_o;
    end
    chk("thr_in_flight", seen, 1);
    #1;
    nrst_i = 1'b0;
    #1;
    check_reset_outputs("mid_thr");
    push_init();
    repeat (3) @(negedge clk);
    withhold_thr = 1'b0;
    #1;
    nrst_i = 1'b1;
    wait_idle("reinit_and_resend", 1000);

    repeat (5) @(negedge clk);
    chk("final_init_q", init_q.size(), 0);
    chk("final_exp_thr", exp_thr.size(), 0);
    chk("final_exp_rx", exp_rx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
